seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Output-side counterpart to the board's button input path: drives the Spartan-6 board's multiplexed common-anode 7-segment display with processor results.
- Time-multiplexes DIGITS hex nibbles onto one shared segment bus.
- Captures new values on a load strobe, typically a debounced one-shot button pulse or a processor write. A captured value reaches the display only at a frame boundary, so the display never tears.
- Inserts one dead cycle at the start of every digit slot to suppress ghosting.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (min 2).
- ACTIVE_LOW, 1, when 1, seg/dp/an are driven active-low; when 0, active-high.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex value to display; nibble k maps to digit k; digit 0 is rightmost.
- dp_in  in  DIGITS  decimal point per digit; sampled together with value.
- load  in  1  one-cycle capture strobe for value/dp_in.
- lzs_en  in  1  leading-zero suppression enable (live, not latched).
- an  out  DIGITS  digit enables.
- seg  out  7  segments; seg[6:0] = g,f,e,d,c,b,a.
- dp  out  1  decimal point.
- frame_tick  out  1  one-cycle pulse when the digit index wraps from DIGITS-1 to 0.
- busy  out  1  high while a loaded value is pending, not yet displayed.

Behaviour:
- Reset (async assert):
  - prescaler=0, idx=0; display and pending registers=0; pend flag=0.
  - an, seg, dp all inactive (all ones when ACTIVE_LOW=1); frame_tick=0; busy=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On the terminal count, idx increments, wrapping DIGITS-1 -> 0.
  - frame_tick is asserted in the same cycle the idx wrap is registered.
- Load/pending:
  - load=1 captures value/dp_in into pending and sets pend; a later load before the boundary overwrites pending (last wins).
  - At the frame boundary (terminal count while idx==DIGITS-1), if pend or load is set, display takes the value: the live inputs when load is high in that cycle, otherwise the pending register.
  - pend clears at the boundary. busy = pend, registered.
  - Load coincident with the boundary: the value shows in the new frame and pend stays 0.
- Outputs are registered and reflect idx/prescaler one cycle later:
  - When prescaler==0 (dead cycle): all anodes inactive; seg and dp inactive.
  - Otherwise: an[idx] active, all other anodes inactive; seg = decode(display nibble idx); dp = display dp bit idx.
- Decode, active-high gfedcba, hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- ACTIVE_LOW=1 inverts seg, dp and an.
- Leading-zero suppression (lzs_en=1):
  - Digit k>0 is blanked (anode inactive) if nibble k and every higher nibble are 0 and their dp bits are 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Reset mid-frame: immediate return to reset state; any pending value is discarded.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, REFRESH_DIV=4, DIGITS=4, ACTIVE_LOW=1 -> an=4'b1111, seg=7'h7F, dp=1 during reset. After release, slots of 4 cycles each, with the digit 0 slot showing an=4'b1110 and seg=~7'h3F=7'h40 (display=0); one dead cycle of an=4'b1111 precedes each slot.
2. load with value=16'h12AF, dp_in=4'b0100 mid-frame -> busy=1 until the wrap. Next frame shows digit0 seg=~7'h71, digit1 ~7'h77, digit2 ~7'h5B with dp=0 (active), digit3 ~7'h06. busy=0 after the boundary.
3. Two loads in one frame (16'h1111, then 16'h2222) -> only 2222 is displayed; 1111 never appears on seg.
4. load of 16'h0BEE asserted exactly in the boundary cycle -> the new frame shows 0BEE immediately; busy never rises.
5. lzs_en=1, value=16'h0050 -> digits 3 and 2 keep an inactive in all their slots; digit1 shows ~7'h6D, digit0 shows ~7'h3F. value=0 -> only digit0 lit, showing ~7'h3F.
6. rst_n pulsed low mid-slot with a pending load -> outputs go inactive at once. After release the display shows 0000 (pending discarded), busy=0, and frame_tick first pulses after 4*4 cycles.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: frame-synchronous value capture, one dead
// cycle per digit slot, optional leading-zero suppression, registered outputs.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  lzs_en,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick,
  output logic                  busy
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp_val;
  logic [DIGITS-1:0]     disp_dp;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend;

  logic                  terminal;
  logic                  last_digit;
  logic                  boundary;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     blank;
  logic                  zero_run;
  logic [DIGITS-1:0]     an_hi;
  logic [6:0]            seg_hi;
  logic                  dp_hi;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign terminal   = (presc == PW'(REFRESH_DIV - 1));
  assign last_digit = (idx == IW'(DIGITS - 1));
  assign boundary   = terminal && last_digit;
  assign busy       = pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (terminal) begin
        presc <= '0;
        idx   <= last_digit ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  // The display registers only change at a frame boundary, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend     <= 1'b0;
    end else if (boundary) begin
      pend <= 1'b0;
      if (load) begin
        disp_val <= value;
        disp_dp  <= dp_in;
      end else if (pend) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
    end else if (load) begin
      pend_val <= value;
      pend_dp  <= dp_in;
      pend     <= 1'b1;
    end
  end

  // A digit above 0 is blank when it and every higher digit is a zero without a dot.
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (disp_val[4*k +: 4] == 4'h0) && !disp_dp[k];
      blank[k] = zero_run;
    end
  end

  always_comb begin
    an_hi  = '0;
    seg_hi = '0;
    dp_hi  = 1'b0;
    nib    = disp_val[{idx, 2'b00} +: 4];
    if (presc != '0 && !(lzs_en && blank[idx])) begin
      an_hi[idx] = 1'b1;
      seg_hi     = decode(nib);
      dp_hi      = disp_dp[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= {DIGITS{ACTIVE_LOW}};
      seg <= {7{ACTIVE_LOW}};
      dp  <= ACTIVE_LOW;
    end else begin
      an  <= ACTIVE_LOW ? ~an_hi  : an_hi;
      seg <= ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp  <= ACTIVE_LOW ? ~dp_hi  : dp_hi;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle-accurate reference model from
// the display rules, table of per-digit expectations, corner-case sequences, random loads.
module tb_seg7_scan_driver;
  localparam int D = 4;
  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          load;
  logic          lzs_en;
  logic [3:0]    an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_tick;
  logic          busy;

  seg7_scan_driver #(.DIGITS(D), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .load(load),
    .lzs_en(lzs_en), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] hex_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the scan is derived from the elapsed cycle count.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pf;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_tick, exp_busy, exp_blank;

  logic [3:0]  obs_lit;
  logic [6:0]  obs_seg [4];
  logic [3:0]  obs_dp;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  lit;
    logic [27:0] segs;
    logic [3:0]  dps;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pf = 1'b0;
  endtask

  function automatic bit next_is_boundary();
    return ((t % R) == R - 1) && (((t / R) % D) == D - 1);
  endfunction

  task automatic model_step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                            input logic lz);
    int presc, dig;
    bit bnd;
    presc = t % R;
    dig   = (t / R) % D;
    bnd   = next_is_boundary();
    exp_blank = lz && dig > 0 && ((m_disp >> (4 * dig)) == 16'h0) && ((m_ddp >> dig) == 4'h0);
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    if (presc != 0 && !exp_blank) begin
      exp_an[dig] = 1'b0;
      exp_seg = ~hex_lut[(m_disp >> (4 * dig)) & 16'hF];
      exp_dp  = ~m_ddp[dig];
    end
    exp_tick = bnd;
    exp_busy = bnd ? 1'b0 : (m_pf || ld);
    if (bnd) begin
      if (ld) begin m_disp = v; m_ddp = d; end
      else if (m_pf) begin m_disp = m_pend; m_ddp = m_pdp; end
      m_pf = 1'b0;
    end else if (ld) begin
      m_pend = v; m_pdp = d; m_pf = 1'b1;
    end
    t++;
  endtask

  task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic [3:0] d,
                               input logic lz);
    load = ld; value = v; dp_in = d; lzs_en = lz;
    model_step(ld, v, d, lz);
    @(posedge clk); #1;
    check("an", an, exp_an);
    if (!exp_blank || (t - 1) % R == 0) begin
      check("seg", seg, exp_seg);
      check("dp", dp, exp_dp);
    end
    check("frame_tick", frame_tick, exp_tick);
    check("busy", busy, exp_busy);
    for (int k = 0; k < D; k++)
      if (an[k] == 1'b0) begin
        obs_lit[k] = 1'b1; obs_seg[k] = seg; obs_dp[k] = dp;
      end
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 4'h0, lz);
  endtask

  task automatic wait_tick(input logic lz, output int cycles);
    cycles = 0;
    do begin
      applyStimulus(1'b0, 16'h0, 4'h0, lz);
      cycles++;
    end while (frame_tick !== 1'b1 && cycles < 3 * D * R);
    if (frame_tick !== 1'b1) check("tick_timeout", 0, 1);
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    obs_lit = '0; obs_dp = '1;
    for (int k = 0; k < D; k++) obs_seg[k] = 7'h7F;
    idle(D * R, v.lz);
    check({tag, "_lit"}, ~obs_lit, ~v.lit);
    for (int k = 0; k < D; k++)
      if (v.lit[k]) begin
        check({tag, "_seg"}, obs_seg[k], v.segs[7*k +: 7]);
        check({tag, "_dp"}, obs_dp[k], v.dps[k]);
      end
  endtask

  task automatic check_inactive(input string tag);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_dp"}, dp, 1'b1);
    check({tag, "_tick"}, frame_tick, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    bit seen_one;
    vecs[0] = '{16'h12AF, 4'b0100, 1'b0, 4'b1111, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1011};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vecs[3] = '{16'h0BEE, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h03, 7'h06, 7'h06}, 4'b1111};
    vecs[4] = '{16'h0BEE, 4'b0000, 1'b1, 4'b0111, {7'h7F, 7'h03, 7'h06, 7'h06}, 4'b1111};
    vecs[5] = '{16'h0020, 4'b1000, 1'b1, 4'b1111, {7'h40, 7'h40, 7'h24, 7'h40}, 4'b0111};
    vecs[6] = '{16'h89CD, 4'b0001, 1'b0, 4'b1111, {7'h00, 7'h10, 7'h46, 7'h21}, 4'b1110};
    vecs[7] = '{16'h3456, 4'b0000, 1'b0, 4'b1111, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b1111};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
    vecs[9] = '{16'h7001, 4'b0010, 1'b1, 4'b1111, {7'h78, 7'h40, 7'h40, 7'h79}, 4'b1101};

    rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lzs_en = 1'b0;
    #12;
    check_inactive("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    $display("[TB] initial frame shows 0000 with dead cycles");
    checkOutput(vecs[8], "rst_frame");

    $display("[TB] table vectors: load mid-frame, show on next frame");
    for (int i = 0; i < 10; i++) begin
      wait_tick(vecs[i].lz, cyc);
      idle(3, vecs[i].lz);
      applyStimulus(1'b1, vecs[i].value, vecs[i].dp, vecs[i].lz);
      check("busy_pending", busy, 1'b1);
      wait_tick(vecs[i].lz, cyc);
      check("busy_cleared", busy, 1'b0);
      checkOutput(vecs[i], "vec");
    end

    $display("[TB] two loads in one frame, last wins");
    applyStimulus(1'b1, 16'h0000, 4'h0, 1'b0);
    wait_tick(1'b0, cyc);
    wait_tick(1'b0, cyc);
    idle(2, 1'b0);
    applyStimulus(1'b1, 16'h1111, 4'h0, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b1, 16'h2222, 4'h0, 1'b0);
    seen_one = 1'b0;
    cyc = 0;
    while (frame_tick !== 1'b1 && cyc < 3 * D * R) begin
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
      if (seg == 7'h79) seen_one = 1'b1;
      cyc++;
    end
    for (int i = 0; i < D * R; i++) begin
      applyStimulus(1'b0, 16'h0, 4'h0, 1'b0);
      if (seg == 7'h79) seen_one = 1'b1;
    end
    check("never_1111", seen_one, 1'b0);
    check("shows_2222", obs_seg[3], 7'h24);

    $display("[TB] load coincident with the frame boundary");
    cyc = 0;
    while (!next_is_boundary() && cyc < 2 * D * R) begin
      idle(1, 1'b0);
      cyc++;
    end
    applyStimulus(1'b1, 16'h0BEE, 4'h0, 1'b0);
    check("boundary_tick", frame_tick, 1'b1);
    check("boundary_busy", busy, 1'b0);
    checkOutput(vecs[3], "bnd");

    $display("[TB] reset mid-slot with a pending load");
    wait_tick(1'b0, cyc);
    idle(6, 1'b0);
    applyStimulus(1'b1, 16'hFACE, 4'hF, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_inactive("midreset");
    @(posedge clk); #1;
    check_inactive("midreset_hold");
    rst_n = 1'b1;
    model_reset();
    wait_tick(1'b0, cyc);
    check("first_tick_cycles", cyc, D * R);
    checkOutput(vecs[8], "after_reset");

    $display("[TB] randomized loads against the model");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom_range(7) == 0), 16'($urandom), 4'($urandom),
                    ($urandom_range(3) == 0) ? ~lzs_en : lzs_en);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
